row_read_sequencer: RTL and testbench
=====================================

# row_read_sequencer

Streams a run of wide rows out of the matrix row RAM, where each row is DATA_RATIO words of DATA_WIDTH bits. The block sits directly downstream of the asymmetric write-side RAM, which is loaded one narrow word at a time. It accepts a command holding a base byte address and a row count. It drives the RAM read address, absorbs the RAM's 1-cycle read latency, and presents rows on a valid/ready stream to the multiply array, with full throughput under backpressure.

## Interface
- DATA_RATIO, 8, words per wide row
- ADDR_DEPTH, 32, rows in the RAM
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, narrow word width (bits)
- CNT_WIDTH, 16, row-count width
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_base_addr  in  ADDR_WIDTH  byte address of first row
- cmd_count  in  CNT_WIDTH  rows to read; 0 is legal
- mem_if_address  out  ADDR_WIDTH  RAM byte address
- mem_if_read_data  in  DATA_RATIO*DATA_WIDTH  RAM read data; valid 1 cycle after address
- m_valid  out  1  row valid
- m_ready  in  1  consumer ready
- m_data  out  DATA_RATIO*DATA_WIDTH  row data; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- m_last  out  1  final row of the command
- done  out  1  one-cycle pulse at command completion

## Operation
- ROW_BYTES = DATA_RATIO*DATA_WIDTH/8. Row i address = cmd_base_addr + i*ROW_BYTES, modulo 2^ADDR_WIDTH (wrap-around, no error).
- The base address must be ROW_BYTES-aligned. The low $clog2(ROW_BYTES) bits are forced to 0.
- FSM states:
  - IDLE: cmd_ready=1. On accept: load the address register with the base, and latch count. count==0 → stay in IDLE and pulse done next cycle. Otherwise go to ISSUE.
  - ISSUE: issue one read per permitted cycle. Advance the address by ROW_BYTES after each issue. After issue number count, go to DRAIN.
  - DRAIN: wait for the m_last handshake, then go to IDLE.
- Issue permitted when fifo_entries + in_flight − pop < 2. pop = m_valid & m_ready.
- in_flight is a 1-bit flag set on the issue cycle. Data returning the next cycle is written to the 2-entry output FIFO.
- This credit rule guarantees the FIFO never overflows.
- m_last is stored alongside each FIFO entry. It is set on the entry from issue number count.
- cmd_ready=0 outside IDLE. Commands are never queued.
- mem_if_address holds its last value when not issuing. The RAM's continuous reads outside issue cycles are discarded.
- This block never writes the RAM; the top level ties the write port to 0.

## Timing
- Accept at cycle 0 → first address in cycle 1 → RAM data in cycle 2 → m_valid in cycle 3.
- With m_ready held high: one row per cycle, no bubbles.
- done pulses the cycle after the m_last handshake. cmd_ready is high in that same cycle, so a back-to-back command is accepted there.
- Count 0: accept at cycle 0, done at cycle 1, no m_valid, no issue.
- Once m_valid rises, m_data, m_last and m_valid hold stable until the handshake.
- rst in any state, including mid-command:
  - next cycle: state IDLE, FIFO empty, in_flight 0; a returning read is dropped.
  - Reset values: cmd_ready 1, m_valid 0, m_last 0, m_data 0, done 0, mem_if_address 0.

## Configuration
- ROW_READ_SEQ_STRIDE_EN defined:
  - adds input cmd_stride [ADDR_WIDTH], latched on accept.
  - Row i address = base + i*cmd_stride, modulo 2^ADDR_WIDTH, with the low bits forced to 0.
  - Used for column-tile walks.
- Not defined: no cmd_stride port; the stride is ROW_BYTES.

## Structure
- Package mm_pkg:
  - row_seq_state_t enum {IDLE, ISSUE, DRAIN}
  - function row_bytes(DATA_RATIO, DATA_WIDTH)
  - localparam OUT_FIFO_DEPTH = 2
- Sub-module row_skid_fifo:
  - 2-entry, width DATA_RATIO*DATA_WIDTH+1
  - push/pop/entries/valid ports
  - registered outputs

## Test plan
- Base 0x40, count 4, m_ready=1 (DATA_RATIO=8, DATA_WIDTH=32, ROW_BYTES=32) → addresses 0x40, 0x60, 0x80, 0xA0 on cycles 1–4. m_valid on cycles 3–6, m_last on cycle 6, done on cycle 7.
- Count 0 → done at cycle 1, m_valid never asserts, mem_if_address unchanged.
- Count 6, m_ready toggled 1,0,0,1,… → exactly 6 rows in address order, no loss or duplication, FIFO never above 2 entries, m_data stable while stalled.
- Base 0xFFFF_FFE0, count 2 → second address 0x0000_0000.
- rst asserted for 1 cycle at cycle 4 of a count-8 run → m_valid 0 and cmd_ready 1 at cycle 5. A new count-1 command then completes normally with no stale row.
- Back-to-back: second command presented during the first command's done cycle → accepted, with its first m_valid 3 cycles later.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix row read path.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } row_seq_state_t;

    localparam int unsigned OUT_FIFO_DEPTH = 2;
    localparam int unsigned OUT_FIFO_CNT_W = $clog2(OUT_FIFO_DEPTH + 1);

    // Bytes occupied by one wide row in the RAM address space.
    function automatic int unsigned row_bytes(input int unsigned data_ratio,
                                              input int unsigned data_width);
        return (data_ratio * data_width) / 8;
    endfunction

endpackage

// File: rtl/row_skid_fifo.sv
// Two-entry output FIFO with registered head data/valid; head is the presented entry.
module row_skid_fifo
    import mm_pkg::*;
#(
    parameter int unsigned WIDTH = 257
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      valid,
    output logic [OUT_FIFO_CNT_W-1:0] entries
);

    logic [WIDTH-1:0]          head_q, head_d;
    logic [WIDTH-1:0]          tail_q, tail_d;
    logic [OUT_FIFO_CNT_W-1:0] entries_q, entries_d;
    logic                      valid_q, valid_d;
    logic                      pop_ok;

    assign pop_ok = pop & valid_q;

    // Head always holds the oldest entry; tail only fills when two are held.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        entries_d = entries_q;
        case ({push, pop_ok})
            2'b10: begin
                if (entries_q == '0) head_d = push_data;
                else                 tail_d = push_data;
                entries_d = entries_q + OUT_FIFO_CNT_W'(1);
            end
            2'b01: begin
                head_d    = tail_q;
                entries_d = entries_q - OUT_FIFO_CNT_W'(1);
            end
            2'b11: begin
                if (entries_q == OUT_FIFO_CNT_W'(1)) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
        valid_d = (entries_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            entries_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
            valid_q   <= valid_d;
        end
    end

    assign pop_data = head_q;
    assign valid    = valid_q;
    assign entries  = entries_q;

endmodule

// File: rtl/row_read_sequencer.sv
// Streams a run of wide rows from the row RAM onto a valid/ready stream.
// Optional ROW_READ_SEQ_STRIDE_EN adds a per-command cmd_stride (default stride is one row).
module row_read_sequencer
    import mm_pkg::*;
#(
    parameter int unsigned DATA_RATIO = 8,
    parameter int unsigned ADDR_DEPTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_WIDTH-1:0]            cmd_base_addr,
    input  logic [CNT_WIDTH-1:0]             cmd_count,
`ifdef ROW_READ_SEQ_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0]            cmd_stride,
`endif
    output logic [ADDR_WIDTH-1:0]            mem_if_address,
    input  logic [DATA_RATIO*DATA_WIDTH-1:0] mem_if_read_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_RATIO*DATA_WIDTH-1:0] m_data,
    output logic                             m_last,
    output logic                             done
);

    localparam int unsigned ROW_W     = DATA_RATIO * DATA_WIDTH;
    localparam int unsigned ROW_BYTES = row_bytes(DATA_RATIO, DATA_WIDTH);
    localparam int unsigned DEPTH_CHK = ADDR_DEPTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(ROW_BYTES - 1);

    row_seq_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]      rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]     next_raw_q, next_raw_d;
    logic [ADDR_WIDTH-1:0]     stride_q, stride_d;
    logic                      in_flight_q, in_flight_d;
    logic                      in_flight_last_q, in_flight_last_d;
    logic                      done_q, done_d;

    logic [ADDR_WIDTH-1:0]     stride_in;
    logic                      accept, pop, issue, last_issue, credit_ok;
    logic [ROW_W:0]            fifo_out;
    logic                      fifo_valid;
    logic [OUT_FIFO_CNT_W-1:0] fifo_entries;

`ifdef ROW_READ_SEQ_STRIDE_EN
    assign stride_in = cmd_stride;
`else
    assign stride_in = ADDR_WIDTH'(ROW_BYTES);
`endif

    assign cmd_ready  = (state_q == IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign pop        = fifo_valid & m_ready;
    // Occupied FIFO slots plus the read still in the RAM must leave room after this cycle's pop.
    assign credit_ok  = (3'(fifo_entries) + 3'(in_flight_q)) < (3'd2 + 3'(pop));
    assign issue      = (state_q == ISSUE) & credit_ok;
    assign last_issue = issue & (rem_q == CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && cmd_count != '0) state_d = ISSUE;
            ISSUE:   if (last_issue)                state_d = DRAIN;
            DRAIN:   if (pop && fifo_out[ROW_W])    state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Address walk keeps the unmasked running sum so non-aligned strides accumulate exactly.
    always_comb begin
        rem_d            = rem_q;
        addr_d           = addr_q;
        next_raw_d       = next_raw_q;
        stride_d         = stride_q;
        in_flight_d      = issue;
        in_flight_last_d = last_issue;
        done_d           = 1'b0;
        if (accept) begin
            if (cmd_count == '0) begin
                done_d = 1'b1;
            end else begin
                addr_d     = cmd_base_addr & ADDR_MASK;
                next_raw_d = cmd_base_addr + stride_in;
                stride_d   = stride_in;
                rem_d      = cmd_count;
            end
        end
        if (issue) begin
            addr_d     = next_raw_q & ADDR_MASK;
            next_raw_d = next_raw_q + stride_q;
            rem_d      = rem_q - CNT_WIDTH'(1);
        end
        if (pop && fifo_out[ROW_W]) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q            <= '0;
            addr_q           <= '0;
            next_raw_q       <= '0;
            stride_q         <= ADDR_WIDTH'(ROW_BYTES);
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            rem_q            <= rem_d;
            addr_q           <= addr_d;
            next_raw_q       <= next_raw_d;
            stride_q         <= stride_d;
            in_flight_q      <= in_flight_d;
            in_flight_last_q <= in_flight_last_d;
            done_q           <= done_d;
        end
    end

    row_skid_fifo #(
        .WIDTH (ROW_W + 1)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data ({in_flight_last_q, mem_if_read_data}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .valid     (fifo_valid),
        .entries   (fifo_entries)
    );

    assign mem_if_address = addr_q;
    assign m_valid        = fifo_valid;
    assign m_data         = fifo_out[ROW_W-1:0];
    assign m_last         = fifo_out[ROW_W];
    assign done           = done_q;

    if (DEPTH_CHK == 0) begin : g_bad_depth
        $error("ADDR_DEPTH must be nonzero");
    end

endmodule

// File: tb/tb_row_read_sequencer.sv
// Scoreboard bench for row_read_sequencer: behavioural RAM + expected-row queue + stream monitor.
module tb_row_read_sequencer;

    localparam int unsigned DR    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned CW    = 16;
    localparam int unsigned ROW_W = DR * DW;
    localparam int unsigned RB    = DR * DW / 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base_addr = '0;
    logic [CW-1:0]    cmd_count = '0;
`ifdef ROW_READ_SEQ_STRIDE_EN
    logic [AW-1:0]    cmd_stride = AW'(RB);
`endif
    logic [AW-1:0]    mem_if_address;
    logic [ROW_W-1:0] mem_if_read_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [ROW_W-1:0] m_data;
    logic             m_last;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 0;
    logic [ROW_W:0] exp_q [$];

    row_read_sequencer #(
        .DATA_RATIO(DR), .ADDR_DEPTH(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_base_addr    (cmd_base_addr),
        .cmd_count        (cmd_count),
`ifdef ROW_READ_SEQ_STRIDE_EN
        .cmd_stride       (cmd_stride),
`endif
        .mem_if_address   (mem_if_address),
        .mem_if_read_data (mem_if_read_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .done             (done)
    );

    always #5 clk = ~clk;

    // RAM content is a function of the byte address so every row is distinguishable.
    function automatic logic [ROW_W-1:0] ram_row(input logic [AW-1:0] a);
        logic [ROW_W-1:0] r;
        for (int k = 0; k < int'(DR); k++) r[k*DW +: DW] = (a * 32'd3) + 32'(k) * 32'h1000_0001;
        return r;
    endfunction

    always @(posedge clk) mem_if_read_data <= ram_row(mem_if_address);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: row i lives at (base + i*stride) mod 2^32 with the in-row offset cleared.
    task automatic model_push(input logic [AW-1:0] base, input int count, input logic [AW-1:0] stride);
        logic [AW-1:0] a;
        for (int i = 0; i < count; i++) begin
            a = (base + AW'(i) * stride) & ~AW'(RB - 1);
            exp_q.push_back({(i == count - 1), ram_row(a)});
        end
    endtask

    // Consumer ready pattern: always, 1,0,0,1 repeating, or random.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing.
    initial begin
        logic done_pending = 1'b0;
        logic p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_rst = 1'b1;
        logic [ROW_W-1:0] p_data = '0;
        logic [ROW_W:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("done", done, done_pending);
                if (p_valid && !p_ready && !p_rst) begin
                    check("stall_valid", m_valid, 1'b1);
                    check("stall_last", m_last, p_last);
                    check_row("stall_data", m_data, p_data);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_row", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check_row("row_data", m_data, e[ROW_W-1:0]);
                        check("row_last", m_last, e[ROW_W]);
                    end
                end
                done_pending = (m_valid && m_ready && m_last) ||
                               (cmd_valid && cmd_ready && cmd_count == '0);
            end else begin
                done_pending = 1'b0;
            end
            p_valid = m_valid; p_ready = m_ready; p_last = m_last; p_data = m_data; p_rst = rst;
        end
    end

    // Presents a command from just after a clock edge; returns at the start of cycle 1.
    task automatic send_cmd(input logic [AW-1:0] base, input int count, input logic [AW-1:0] stride);
        bit ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base_addr = base; cmd_count = CW'(count);
`ifdef ROW_READ_SEQ_STRIDE_EN
        cmd_stride = stride;
`endif
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                model_push(base, count, stride);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && cmd_ready && !m_valid;
        end
        if (!ok) check("drain_timeout", 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] hold_addr;
        logic [AW-1:0] stride;
        int cnt;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data_nz", 64'(|m_data), 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", mem_if_address, '0);

        // Directed: base 0x40 count 4, then a back-to-back count-2 command in the done cycle.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base_addr = 32'h40; cmd_count = CW'(4);
        @(negedge clk);
        check("c0_cmd_ready", cmd_ready, 1'b1);
        model_push(32'h40, 4, AW'(RB));
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("dir_valid_c%0d", c), m_valid, (c >= 3 && c <= 6) || (c >= 10 && c <= 11));
            check($sformatf("dir_last_c%0d", c), m_valid & m_last, c == 6 || c == 11);
            check($sformatf("dir_ready_c%0d", c), cmd_ready, c == 7 || c == 12);
            if (c <= 4) check($sformatf("dir_addr_c%0d", c), mem_if_address, 32'h40 + 32'(c - 1) * 32);
            if (c == 8 || c == 9) check($sformatf("dir_addr_c%0d", c), mem_if_address, 32'h100 + 32'(c - 8) * 32);
            if (c == 6) begin
                @(posedge clk); #1;
                cmd_valid = 1'b1; cmd_base_addr = 32'h100; cmd_count = CW'(2);
            end else if (c == 7) begin
                model_push(32'h100, 2, AW'(RB));
                @(posedge clk); #1 cmd_valid = 1'b0;
            end
        end
        wait_idle();

        // Count 0: done next cycle, no row, address untouched.
        hold_addr = mem_if_address;
        send_cmd(32'h300, 0, AW'(RB));
        @(negedge clk);
        check("cnt0_done", done, 1'b1);
        check("cnt0_addr", mem_if_address, hold_addr);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("cnt0_no_valid", m_valid, 1'b0);
        end

        // Count 6 under 1,0,0,1 backpressure.
        ready_mode = 1;
        send_cmd(32'h80, 6, AW'(RB));
        wait_idle();
        ready_mode = 0;

        // Address wrap-around.
        send_cmd(32'hFFFF_FFE0, 2, AW'(RB));
        @(negedge clk);
        check("wrap_addr0", mem_if_address, 32'hFFFF_FFE0);
        @(negedge clk);
        check("wrap_addr1", mem_if_address, 32'h0);
        wait_idle();

        // Reset mid-command at cycle 4 of a count-8 run.
        send_cmd(32'h400, 8, AW'(RB));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", m_valid, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b1);
        check("mid_rst_addr", mem_if_address, '0);
        send_cmd(32'h200, 1, AW'(RB));
        wait_idle();

        // Random commands under random backpressure.
        ready_mode = 2;
        for (int n = 0; n < 25; n++) begin
            cnt = $urandom_range(0, 9);
`ifdef ROW_READ_SEQ_STRIDE_EN
            stride = $urandom;
`else
            stride = AW'(RB);
`endif
            send_cmd($urandom, cnt, stride);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
